tdp_sync_fifo: RTL and testbench



---
 rtl/tdp_sync_fifo.sv | 143 ++++++++++++++
 tb/tb_tdp_sync_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tdp_sync_fifo.sv
// Parametrised single-clock FIFO with level output and the eight-flag status set.
// Define TDP_SYNC_FIFO_FWFT_EN for a first-word-fall-through read path; default is a 1-cycle registered read.
module tdp_sync_fifo #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10,
    parameter int UPAE       = 4,
    parameter int UPAF       = 4
) (
    input  logic                  CLK_i,
    input  logic                  RST_i,
    input  logic                  WEN_i,
    input  logic [DATA_WIDTH-1:0] WDATA_i,
    input  logic                  REN_i,
    output logic [DATA_WIDTH-1:0] RDATA_o,
    output logic [ADDR_WIDTH:0]   LEVEL_o,
    output logic                  EMPTY_o,
    output logic                  EPO_o,
    output logic                  EWM_o,
    output logic                  UNDERRUN_o,
    output logic                  FULL_o,
    output logic                  FMO_o,
    output logic                  FWM_o,
    output logic                  OVERRUN_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH:0] PTR_ONE      = PW'(1);
    localparam logic [ADDR_WIDTH:0] LVL_ZERO     = PW'(0);
    localparam logic [ADDR_WIDTH:0] LVL_ONE      = PW'(1);
    localparam logic [ADDR_WIDTH:0] LVL_DEPTH    = PW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LVL_DEPTH_M1 = PW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] LVL_AE       = PW'(UPAE);
    localparam logic [ADDR_WIDTH:0] LVL_AF       = PW'(DEPTH - UPAF);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [ADDR_WIDTH:0] wr_ptr_r;
    logic [ADDR_WIDTH:0] rd_ptr_r;
    logic [ADDR_WIDTH:0] level_r;
    logic [ADDR_WIDTH:0] wr_ptr_nxt_s;
    logic [ADDR_WIDTH:0] rd_ptr_nxt_s;
    logic [ADDR_WIDTH:0] level_nxt_s;
    logic                wr_acc_s;
    logic                rd_acc_s;

    logic empty_r;
    logic epo_r;
    logic ewm_r;
    logic full_r;
    logic fmo_r;
    logic fwm_r;
    logic underrun_r;
    logic overrun_r;

    // Accept gating from registered flags and next-state pointer/level computation
    always_comb begin
        wr_acc_s     = WEN_i & ~full_r;
        rd_acc_s     = REN_i & ~empty_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (wr_acc_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_acc_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        // Wrap bit makes the modulo difference distinguish full from empty
        level_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    end

    // Pointer, level and status flag registers
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            wr_ptr_r   <= LVL_ZERO;
            rd_ptr_r   <= LVL_ZERO;
            level_r    <= LVL_ZERO;
            empty_r    <= 1'b1;
            epo_r      <= 1'b0;
            ewm_r      <= 1'b1;
            full_r     <= 1'b0;
            fmo_r      <= 1'b0;
            fwm_r      <= 1'b0;
            underrun_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            level_r    <= level_nxt_s;
            empty_r    <= (level_nxt_s == LVL_ZERO);
            epo_r      <= (level_nxt_s == LVL_ONE);
            ewm_r      <= (level_nxt_s <= LVL_AE);
            full_r     <= (level_nxt_s == LVL_DEPTH);
            fmo_r      <= (level_nxt_s == LVL_DEPTH_M1);
            fwm_r      <= (level_nxt_s >= LVL_AF);
            underrun_r <= REN_i & empty_r;
            overrun_r  <= WEN_i & full_r;
        end
    end

    // Storage array write port; contents are deliberately not reset
    always_ff @(posedge CLK_i) begin
        if (wr_acc_s && !RST_i) begin
            mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= WDATA_i;
        end
    end

`ifdef TDP_SYNC_FIFO_FWFT_EN
    // Head of queue is presented combinationally; valid whenever not empty
    assign RDATA_o = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
`else
    logic [DATA_WIDTH-1:0] rdata_r;

    // Registered read: load on accepted read, hold otherwise
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_acc_s) begin
            rdata_r <= mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign RDATA_o = rdata_r;
`endif

    assign LEVEL_o    = level_r;
    assign EMPTY_o    = empty_r;
    assign EPO_o      = epo_r;
    assign EWM_o      = ewm_r;
    assign UNDERRUN_o = underrun_r;
    assign FULL_o     = full_r;
    assign FMO_o      = fmo_r;
    assign FWM_o      = fwm_r;
    assign OVERRUN_o  = overrun_r;

endmodule

// File: tb/tb_tdp_sync_fifo.sv
// Self-checking bench for tdp_sync_fifo (DATA_WIDTH=18, ADDR_WIDTH=4, UPAE=UPAF=4).
// Hand-computed vector table first, then queue-model-checked fill/overrun/drain/wrap/reset sequences.
module tb_tdp_sync_fifo;

    localparam int DW    = 18;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wen;
    logic          ren;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [AW:0]   level;
    logic empty, epo, ewm, underrun, full, fmo, fwm, overrun;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_rd;

    always #5 clk = ~clk;

    tdp_sync_fifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .UPAE(4),
        .UPAF(4)
    ) dut (
        .CLK_i(clk),
        .RST_i(rst),
        .WEN_i(wen),
        .WDATA_i(wdata),
        .REN_i(ren),
        .RDATA_o(rdata),
        .LEVEL_o(level),
        .EMPTY_o(empty),
        .EPO_o(epo),
        .EWM_o(ewm),
        .UNDERRUN_o(underrun),
        .FULL_o(full),
        .FMO_o(fmo),
        .FWM_o(fwm),
        .OVERRUN_o(overrun)
    );

    typedef struct {
        logic          wen;
        logic          ren;
        logic [DW-1:0] wd;
        logic [AW:0]   lvl;
        logic [7:0]    flg;     // {empty,epo,ewm,full,fmo,fwm,underrun,overrun}
        logic [DW-1:0] rd_std;
        logic [DW-1:0] rd_fw;
        logic          fw_chk;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] flags_now();
        return {empty, epo, ewm, full, fmo, fwm, underrun, overrun};
    endfunction

    // One clock against the queue model; entered and left on a falling edge
    task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d,
                        input string tag);
        bit full_b, empty_b, und_b, ovr_b;
        int n;
        logic [7:0] ef;
        full_b  = (q.size() == DEPTH);
        empty_b = (q.size() == 0);
        rst = r; wen = w; ren = rd; wdata = d;
        @(negedge clk);
        und_b = 1'b0;
        ovr_b = 1'b0;
        if (r) begin
            q.delete();
            exp_rd = '0;
        end else begin
            und_b = rd && empty_b;
            ovr_b = w && full_b;
            if (rd && !empty_b) exp_rd = q.pop_front();
            if (w && !full_b) q.push_back(d);
        end
        n  = q.size();
        ef = {n == 0, n == 1, n <= 4, n == DEPTH, n == DEPTH - 1, n >= DEPTH - 4, und_b, ovr_b};
        check({tag, " level"}, 32'(level), 32'(n));
        check({tag, " flags"}, 32'(flags_now()), 32'(ef));
`ifdef TDP_SYNC_FIFO_FWFT_EN
        if (n != 0) check({tag, " rdata"}, 32'(rdata), 32'(q[0]));
`else
        check({tag, " rdata"}, 32'(rdata), 32'(exp_rd));
`endif
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 18'h00A11, 5'd1, 8'b0110_0000, 18'h00000, 18'h00A11, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 18'h00B22, 5'd2, 8'b0010_0000, 18'h00000, 18'h00A11, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 18'h00C33, 5'd2, 8'b0010_0000, 18'h00A11, 18'h00B22, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 18'h00000, 5'd1, 8'b0110_0000, 18'h00B22, 18'h00C33, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 18'h00000, 5'd0, 8'b1010_0000, 18'h00C33, 18'h00000, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 18'h00000, 5'd0, 8'b1010_0010, 18'h00C33, 18'h00000, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 18'h01D44, 5'd1, 8'b0110_0010, 18'h00C33, 18'h01D44, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 18'h00000, 5'd0, 8'b1010_0000, 18'h01D44, 18'h00000, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 18'h00000, 5'd0, 8'b1010_0000, 18'h01D44, 18'h00000, 1'b0};

        rst = 1'b1; wen = 1'b0; ren = 1'b0; wdata = '0;
        exp_rd = '0;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 18'h0, "reset");

        // Hand-computed vectors: small fill, concurrent access, underrun, write-while-empty
        for (int i = 0; i < 9; i++) begin
            rst = 1'b0; wen = tbl[i].wen; ren = tbl[i].ren; wdata = tbl[i].wd;
            @(negedge clk);
            check($sformatf("vec%0d level", i), 32'(level), 32'(tbl[i].lvl));
            check($sformatf("vec%0d flags", i), 32'(flags_now()), 32'(tbl[i].flg));
`ifdef TDP_SYNC_FIFO_FWFT_EN
            if (tbl[i].fw_chk) check($sformatf("vec%0d rdata", i), 32'(rdata), 32'(tbl[i].rd_fw));
`else
            check($sformatf("vec%0d rdata", i), 32'(rdata), 32'(tbl[i].rd_std));
`endif
        end

        // Fill 16 words, then overrun attempt, then idle to see the pulse drop
        step(1'b1, 1'b0, 1'b0, 18'h0, "rst2");
        for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 1'b0, DW'(i), $sformatf("fill%0d", i));
        check("full after fill", 32'(full), 32'd1);
        step(1'b0, 1'b1, 1'b0, 18'h3FFFF, "overrun");
        check("overrun pulse", 32'(overrun), 32'd1);
        step(1'b0, 1'b0, 1'b0, 18'h0, "post_overrun");
        check("overrun clear", 32'(overrun), 32'd0);

        // Drain 16 words then one underrun read
        for (int i = 1; i <= 16; i++) step(1'b0, 1'b0, 1'b1, 18'h0, $sformatf("drain%0d", i));
        step(1'b0, 1'b0, 1'b1, 18'h0, "underrun");
        check("underrun pulse", 32'(underrun), 32'd1);
        step(1'b0, 1'b0, 1'b0, 18'h0, "post_underrun");

        // Preload 3, then 40 concurrent write+read cycles across two pointer wraps
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, DW'(18'h00200 + i), "preload");
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1, DW'(18'h00100 + i), $sformatf("wrap%0d", i));
        check("wrap level", 32'(level), 32'd3);

        // Bring level to 9, then reset with both requests asserted
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, DW'(18'h00300 + i), "to9");
        check("level 9", 32'(level), 32'd9);
        step(1'b1, 1'b1, 1'b1, 18'h2AAAA, "midreset");
        check("midreset level", 32'(level), 32'd0);
        check("midreset flags", 32'(flags_now()), 32'(8'b1010_0000));

        // First word into empty FIFO, then a single pop
        step(1'b0, 1'b1, 1'b0, 18'h0ABCD, "first_word");
        check("first_word empty", 32'(empty), 32'd0);
        step(1'b0, 1'b0, 1'b1, 18'h0, "pop");
        check("pop empty", 32'(empty), 32'd1);
`ifndef TDP_SYNC_FIFO_FWFT_EN
        check("pop rdata", 32'(rdata), 32'h0ABCD);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
